// File: rtl/rotate_job_sequencer.sv
// Job FIFO plus beat expander feeding the 8-bit rotate-left barrel shifter.
// Define ROT_CLAMP_EN to store job_max==7 as 6, which keeps the shifter's zeroing code 7 unused.
module rotate_job_sequencer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [7:0]       job_data,
  input  logic [2:0]       job_max,
  input  logic             abort,
  output logic             sh_valid,
  input  logic             sh_ready,
  output logic [7:0]       sh_d_in,
  output logic [2:0]       sh_amount,
  output logic             sh_last,
  output logic             busy,
  output logic [PTR_W:0]   fifo_count
);

  localparam logic [PTR_W:0] LP_DEPTH = (PTR_W+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [7:0]       r_mem_d [DEPTH];
  logic [2:0]       r_mem_m [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [7:0]       r_d;
  logic [2:0]       r_amt;
  logic [2:0]       r_max;
  logic             r_valid;
  logic             r_last;

  logic       w_push;
  logic       w_pop;
  logic       w_hs;
  logic [2:0] w_max_in;
  logic [7:0] w_head_d;
  logic [2:0] w_head_m;

`ifdef ROT_CLAMP_EN
  assign w_max_in = (job_max == 3'd7) ? 3'd6 : job_max;
`else
  assign w_max_in = job_max;
`endif

  assign job_ready = !rst && (r_count != LP_DEPTH);
  assign w_push    = job_valid && job_ready && !abort;
  assign w_hs      = r_valid && sh_ready;
  // Pop needs an occupied FIFO at the start of the cycle; a same-cycle push cannot feed it.
  assign w_pop     = (r_count != '0) && ((r_state == S_IDLE) || (w_hs && r_last));
  assign w_head_d  = r_mem_d[r_rd_ptr];
  assign w_head_m  = r_mem_m[r_rd_ptr];

  assign sh_valid   = r_valid;
  assign sh_d_in    = r_d;
  assign sh_amount  = r_amt;
  assign sh_last    = r_last;
  assign busy       = (r_state == S_RUN) || (r_count != '0);
  assign fifo_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_d[r_wr_ptr] <= job_data;
      r_mem_m[r_wr_ptr] <= w_max_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_d      <= '0;
      r_amt    <= '0;
      r_max    <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end else if (abort) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
      // Loading the next job on the last handshake keeps jobs back-to-back.
      if (w_pop) begin
        r_state <= S_RUN;
        r_d     <= w_head_d;
        r_max   <= w_head_m;
        r_amt   <= 3'd0;
        r_last  <= (w_head_m == 3'd0);
        r_valid <= 1'b1;
      end else if ((r_state == S_RUN) && w_hs) begin
        if (r_last) begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end else begin
          r_amt  <= r_amt + 3'd1;
          r_last <= ((r_amt + 3'd1) == r_max);
        end
      end
    end
  end

endmodule
